// File: rtl/fifo.sv
// Single-clock first-word-fall-through FIFO; head word is shown on r_data.
// Ports: clk, reset, rd, wr, w_data -> empty, full, r_data (+ count when FIFO_COUNT_EN).
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  empty,
  output logic                  full,
`ifdef FIFO_COUNT_EN
  output logic [ADDR_WIDTH:0]   count,
`endif
  output logic [DATA_WIDTH-1:0] r_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PONE = 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic                  r_empty;
  logic                  r_full;

  logic [ADDR_WIDTH-1:0] w_wptr_nxt;
  logic [ADDR_WIDTH-1:0] w_rptr_nxt;
  logic                  w_wr_ok;
  logic                  w_rd_ok;

  assign w_wptr_nxt = r_wptr + PONE;
  assign w_rptr_nxt = r_rptr + PONE;

  // A full FIFO still takes a write when the head is popped in the same cycle.
  assign w_wr_ok = wr & (~r_full | rd);
  assign w_rd_ok = rd & ~r_empty;

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wptr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= w_wptr_nxt;
      end
      if (w_rd_ok) begin
        r_rptr <= w_rptr_nxt;
      end
      // Flags move only when exactly one side is accepted.
      unique case ({w_wr_ok, w_rd_ok})
        2'b10: begin
          r_empty <= 1'b0;
          r_full  <= (w_wptr_nxt == r_rptr);
        end
        2'b01: begin
          r_full  <= 1'b0;
          r_empty <= (w_rptr_nxt == r_wptr);
        end
        default: begin
          r_empty <= r_empty;
          r_full  <= r_full;
        end
      endcase
    end
  end

`ifdef FIFO_COUNT_EN
  logic [ADDR_WIDTH:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_wr_ok & ~w_rd_ok) begin
      r_count <= r_count + 1'b1;
    end else if (w_rd_ok & ~w_wr_ok) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
`endif

  assign empty  = r_empty;
  assign full   = r_full;
  assign r_data = r_mem[r_rptr];

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: queue-based reference model, directed + random traffic.
// Monitor checks flags and head data on the falling edge.
module tb_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       empty;
  logic       full;
  logic [7:0] r_data;
`ifdef FIFO_COUNT_EN
  logic [4:0] count;
`endif

  fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .rd(rd),
    .wr(wr),
    .w_data(w_data),
    .empty(empty),
    .full(full),
`ifdef FIFO_COUNT_EN
    .count(count),
`endif
    .r_data(r_data)
  );

  always #5 clk = ~clk;

  localparam int DEPTH = 16;

  logic [7:0] q[$];
  int mocc = 0;
  int cur_occ = 0;
  bit cur_rd = 0;
  bit cur_rst = 0;
  bit cur_armed = 0;
  bit armed = 0;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a bounded queue; a write is taken if there is room or a pop
  // frees a slot in the same cycle, a read is taken if anything is held.
  task automatic step(input bit irst, input bit ird,
                      input bit iwr, input logic [7:0] d);
    bit aw;
    bit ar;
    @(posedge clk);
    #1;
    reset = irst;
    rd = ird;
    wr = iwr;
    w_data = d;
    cur_occ = mocc;
    cur_rst = irst;
    cur_armed = armed;
    if (irst) begin
      cur_rd = 0;
      q.delete();
      mocc = 0;
      armed = 1;
    end else begin
      aw = iwr && (mocc < DEPTH || ird);
      ar = ird && mocc > 0;
      cur_rd = ar;
      if (aw) q.push_back(d);
      mocc = mocc + int'(aw) - int'(ar);
    end
  endtask

  always @(negedge clk) begin
    if (cur_armed) begin
      chk("empty", int'(empty), int'(cur_occ == 0));
      chk("full", int'(full), int'(cur_occ == DEPTH));
`ifdef FIFO_COUNT_EN
      chk("count", int'(count), cur_occ);
`endif
      if (!cur_rst && cur_occ > 0) begin
        if (q.size() == 0) begin
          chk("scoreboard_underrun", 1, 0);
        end else begin
          chk("r_data", int'(r_data), int'(q[0]));
          if (cur_rd) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int pw;
    int pr;
    step(1, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    // first write, then it must fall through
    step(0, 0, 1, 8'h40);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    // back to empty, then fill 0x40,0x40,0x41,0x42,...
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h40);
    step(0, 0, 1, 8'h40);
    for (int i = 0; i < 14; i++) step(0, 0, 1, 8'(8'h41 + i));
    // writes while full are dropped
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h62);
    step(0, 0, 0, 8'h00);
    // drain and over-read
    for (int i = 0; i < 19; i++) step(0, 1, 0, 8'h00);
    // both on empty: write only
    step(0, 1, 1, 8'h77);
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 15; i++) step(0, 0, 1, 8'(8'h80 + i));
    // both on full: pass-through at full
    for (int i = 0; i < 5; i++) step(0, 1, 1, 8'(8'hA0 + i));
    for (int i = 0; i < 17; i++) step(0, 1, 0, 8'h00);
    // reset with 5 held, reset beats rd/wr
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'hC0 + i));
    step(1, 1, 1, 8'hEE);
    step(0, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h5A);
    step(0, 0, 0, 8'h00);
    // random traffic with phases biased toward fill and drain
    for (int ph = 0; ph < 12; ph++) begin
      pw = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 55;
      pr = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 85 : 55;
      for (int i = 0; i < 200; i++) begin
        step(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 99) < pr),
             ($urandom_range(0, 99) < pw),
             8'($urandom));
      end
    end
    step(0, 0, 0, 8'h00);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
